uart_rx: RTL

UART_RX -- requirements
Module: uart_rx

---
 rtl/uart_rx_pkg.sv | 22 ++
 rtl/uart_rx_if.sv | 13 +
 rtl/uart_rx_sync2.sv | 25 ++
 rtl/uart_rx.sv | 128 ++++++++++++
 4 files changed

// File: rtl/uart_rx_pkg.sv
// Shared UART frame constants and receiver FSM encoding.
package uart_rx_pkg;

  localparam int unsigned DATA_BITS  = 8;
  localparam int unsigned STOP_BITS  = 1;
  localparam int unsigned FRAME_BITS = 1 + DATA_BITS + STOP_BITS;
  localparam int unsigned BIT_IDX_W  = 4;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    STOP      = 3'd3,
    WAIT_HIGH = 3'd4
  } rx_state_e;

  // 2-of-3 majority vote of the three centre samples of a bit.
  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_rx_if.sv
// Serial line in, received byte and status out.
interface uart_rx_if;
  import uart_rx_pkg::*;

  logic                 in;
  logic [DATA_BITS-1:0] data;
  logic                 data_rdy;
  logic                 frame_err;
  logic                 busy;

  modport master (output in, input data, data_rdy, frame_err, busy);
  modport slave  (input in, output data, data_rdy, frame_err, busy);
endinterface

// File: rtl/uart_rx_sync2.sv
// Two-flop synchronizer for the asynchronous serial line; idles high.
module uart_rx_sync2 (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o
);

  logic ff1_q = 1'b1;
  logic ff2_q = 1'b1;

  // Resync chain, forced to the idle (high) level on reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      ff1_q <= 1'b1;
      ff2_q <= 1'b1;
    end else begin
      ff1_q <= d_i;
      ff2_q <= ff1_q;
    end
  end

  assign q_o = ff2_q;

endmodule

// File: rtl/uart_rx.sv
// 8n1 UART receiver with OVS-times oversampling and 2-of-3 centre voting.
module uart_rx
  import uart_rx_pkg::*;
#(
  parameter int unsigned OVS = 16
) (
  input  logic         clk,
  input  logic         rst,
  uart_rx_if.slave     bus
);

  localparam int unsigned CNT_W = $clog2(FRAME_BITS * OVS + 1);

  logic sline;

  rx_state_e            state_q = WAIT_HIGH, state_d;
  logic [CNT_W-1:0]     cnt_q   = '0,        cnt_d;
  logic [BIT_IDX_W-1:0] bit_q   = '0,        bit_d;
  logic [1:0]           smp_q   = '0,        smp_d;
  logic [DATA_BITS-1:0] shift_q = '0,        shift_d;
  logic [DATA_BITS-1:0] data_q  = '0,        data_d;
  logic                 ferr_q  = 1'b0,      ferr_d;
  logic                 rdy_q   = 1'b0,      rdy_d;
  logic                 busy_q  = 1'b0,      busy_d;

  logic [CNT_W-1:0]     centre_c;
  logic                 decide_c;
  logic                 maj_c;

  uart_rx_sync2 u_sync (
    .clk (clk),
    .rst (rst),
    .d_i (bus.in),
    .q_o (sline)
  );

  // Centre tick of the current bit and the vote taken one tick after it.
  assign centre_c = CNT_W'(int'(bit_q) * int'(OVS) + int'(OVS / 2));
  assign decide_c = (cnt_q == centre_c + CNT_W'(1));
  assign maj_c    = maj3(smp_q[0], smp_q[1], sline);

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= WAIT_HIGH;
      cnt_q   <= '0;
      bit_q   <= '0;
      smp_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      ferr_q  <= 1'b0;
      rdy_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      smp_q   <= smp_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      ferr_q  <= ferr_d;
      rdy_q   <= rdy_d;
      busy_q  <= busy_d;
    end
  end

  // Next-state: tick counting, centre sampling, bit decisions, frame commit.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CNT_W'(1);
    bit_d   = bit_q;
    smp_d   = smp_q;
    shift_d = shift_q;
    data_d  = data_q;
    ferr_d  = ferr_q;
    rdy_d   = 1'b0;

    if (cnt_q == centre_c - CNT_W'(1)) smp_d[0] = sline;
    if (cnt_q == centre_c)             smp_d[1] = sline;

    unique case (state_q)
      IDLE: begin
        // The cycle that first sees the line low is tick 0.
        cnt_d = CNT_W'(!sline);
        bit_d = '0;
        if (!sline) state_d = START;
      end
      START: begin
        if (decide_c) begin
          bit_d   = bit_q + BIT_IDX_W'(1);
          state_d = maj_c ? IDLE : DATA;
        end
      end
      DATA: begin
        if (decide_c) begin
          shift_d = {maj_c, shift_q[DATA_BITS-1:1]};
          bit_d   = bit_q + BIT_IDX_W'(1);
          if (bit_q == BIT_IDX_W'(DATA_BITS)) state_d = STOP;
        end
      end
      STOP: begin
        if (decide_c) begin
          data_d  = shift_q;
          ferr_d  = ~maj_c;
          rdy_d   = 1'b1;
          state_d = maj_c ? IDLE : WAIT_HIGH;
        end
      end
      WAIT_HIGH: begin
        // A held-low line reports one framing error, then waits for idle.
        cnt_d = '0;
        if (sline) state_d = IDLE;
      end
      default: begin
        cnt_d   = '0;
        state_d = WAIT_HIGH;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  assign bus.data      = data_q;
  assign bus.data_rdy  = rdy_q;
  assign bus.frame_err = ferr_q;
  assign bus.busy      = busy_q;

endmodule
